tick_scheduler: RTL
===================

// Module: tick_scheduler
// PURPOSE
//   Shared timebase for the game logic. One free-running prescaler produces a
//   base tick, and N_CH independently programmable channels divide it.
//   Each channel emits a one-cycle enable strobe (tick) for the animation,
//   movement and spawn logic, plus a 50% square wave (sq) for consumers that
//   still need a slow toggling signal. This replaces the separate per-feature
//   counter dividers; all timing runs in the single clk domain.
// PARAMETERS
//   BASE_DIV    100_000  clk cycles per base tick (1 ms at 100 MHz); >=2
//   N_CH        4        number of channels, 1..4
//   PW          16       period register / channel counter width
//   DEF_PERIOD  240      reset period of every channel, in base ticks
// PORTS
//   clk         in   1        system clock
//   rst         in   1        synchronous reset, active-high
//   run         in   1        1 = prescaler advances; 0 = whole block frozen
//   restart     in   1        1-cycle strobe: realign all channels to phase 0
//   ch_en       in   N_CH     per-channel count enable
//   cfg_we      in   1        1-cycle config write request
//   cfg_ch      in   2        channel index of the write
//   cfg_period  in   PW       new period in base ticks (0 = channel off)
//   cfg_ack     out  1        1-cycle pulse, the cycle after cfg_we
//   cfg_err     out  1        valid with cfg_ack; 1 = cfg_ch >= N_CH, ignored
//   base_tick   out  1        1-cycle strobe at every prescaler wrap
//   tick        out  N_CH     per-channel 1-cycle strobes (registered)
//   sq          out  N_CH     per-channel square wave; toggles on each tick
// BEHAVIOUR
//   Reset: pre=0, cnt[i]=0, per[i]=DEF_PERIOD. All outputs are 0.
//   Prescaler: counts 0..BASE_DIV-1 while run=1. In the cycle pre==BASE_DIV-1,
//     pre wraps to 0 and base_tick is 1 in the following cycle (registered).
//     With run=0, pre, cnt and sq hold, and no strobes are generated.
//   Channel i advances on an internal wrap (wrap = run && pre==BASE_DIV-1)
//     when ch_en[i]=1 and per[i]!=0:
//     - if cnt[i]==per[i]-1: cnt[i]<=0, tick[i]=1 the next cycle, sq[i] toggles
//       in that same next cycle;
//     - else cnt[i]<=cnt[i]+1.
//     tick[i] therefore coincides with base_tick. The tick period is per[i]*BASE_DIV clk cycles.
//   ch_en[i]=0: cnt[i] and sq[i] hold. Re-enabling resumes from the held count.
//   per[i]==0: the channel is off. cnt[i] is forced to 0, no ticks, sq[i] holds.
//   per[i]==1: a tick on every wrap, and sq[i] toggles on every wrap.
//   Config: cfg_we with a valid cfg_ch loads per[cfg_ch]<=cfg_period and clears
//     cnt[cfg_ch]. cfg_ack is asserted the next cycle with cfg_err=0.
//     If cfg_ch>=N_CH, no state changes, and cfg_ack and cfg_err are both 1 the next cycle.
//     Back-to-back cfg_we on consecutive cycles is legal; every one is acked.
//   Collision: if cfg_we to channel i and a wrap land in the same cycle, the write wins.
//     cnt[i]<=0, there is no tick[i] for that wrap, and sq[i] is unchanged.
//   restart: pre<=0, all cnt<=0, sq<=0, and no strobes next cycle. Periods are kept.
//     restart has priority over a wrap and over counting, but a cfg write in the
//     same cycle still loads per.
//   rst mid-operation overrides everything, including an in-flight cfg_ack
//     (cfg_ack is 0 after rst).
//   Arithmetic: all compares are unsigned at PW bits, and counters never exceed per-1.
// TESTING  (sim with BASE_DIV=4, N_CH=4, DEF_PERIOD=3)
//   1. rst, then run=1, ch_en=4'hF -> base_tick every 4 clks; tick[3:0] every 12 clks,
//      aligned with base_tick; sq toggles every 12 clks.
//   2. cfg_we, ch=1, period=1 -> cfg_ack=1 and cfg_err=0 the next cycle; tick[1] then fires
//      on every base_tick. cfg_ch=2 period=0 -> tick[2] never fires, and sq[2] holds.
//   3. N_CH=3 build, cfg_we with cfg_ch=3 -> cfg_ack=1 and cfg_err=1; all periods unchanged.
//   4. cfg_we to ch0 in the same cycle as a wrap that would fire it -> no tick[0].
//      The next tick[0] comes 3 base ticks later.
//   5. run=0 for 50 clks mid-count, and ch_en[0]=0 for 2 base ticks -> no strobes
//      while frozen; counts resume, so tick spacing stretches by exactly the paused time.
//   6. restart at an arbitrary phase, then rst asserted while cfg_ack is pending
//      -> after restart, all ticks are realigned 12 clks out with sq=0.
//      After rst, all outputs are 0 and per is 3 again.

Source files
------------

// File: rtl/tick_scheduler.sv
// tick_scheduler: shared prescaler plus N_CH programmable tick/square-wave dividers
module tick_scheduler #(
  parameter int BASE_DIV   = 100_000,
  parameter int N_CH       = 4,
  parameter int PW         = 16,
  parameter int DEF_PERIOD = 240
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            run,
  input  logic            restart,
  input  logic [N_CH-1:0] ch_en,
  input  logic            cfg_we,
  input  logic [1:0]      cfg_ch,
  input  logic [PW-1:0]   cfg_period,
  output logic            cfg_ack,
  output logic            cfg_err,
  output logic            base_tick,
  output logic [N_CH-1:0] tick,
  output logic [N_CH-1:0] sq
);
  localparam int BW = $clog2(BASE_DIV);
  logic [BW-1:0] pre;
  logic wrap;
  assign wrap = run && pre == BW'(BASE_DIV - 1);
  always_ff @(posedge clk) begin
    if (rst) begin
      pre       <= '0;
      base_tick <= 1'b0;
      cfg_ack   <= 1'b0;
      cfg_err   <= 1'b0;
    end else begin
      pre       <= (restart || wrap) ? '0 : run ? pre + 1'b1 : pre;
      base_tick <= wrap && !restart;
      cfg_ack   <= cfg_we;
      cfg_err   <= cfg_we && 32'(cfg_ch) >= N_CH;
    end
  end
  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    logic [PW-1:0] per, cnt;
    logic wr, adv, hit, tick_r, sq_r;
    // a config write or restart suppresses the wrap for this channel
    assign wr  = cfg_we && cfg_ch == 2'(i);
    assign adv = wrap && ch_en[i] && per != '0 && !wr && !restart;
    assign hit = adv && cnt == per - PW'(1);
    always_ff @(posedge clk) begin
      if (rst) begin
        per    <= PW'(DEF_PERIOD);
        cnt    <= '0;
        tick_r <= 1'b0;
        sq_r   <= 1'b0;
      end else begin
        per    <= wr ? cfg_period : per;
        cnt    <= (restart || wr || hit || per == '0) ? '0 : adv ? cnt + 1'b1 : cnt;
        tick_r <= hit;
        sq_r   <= restart ? 1'b0 : sq_r ^ hit;
      end
    end
    assign tick[i] = tick_r;
    assign sq[i]   = sq_r;
  end
endmodule
